// File: rtl/condicionador_botoes.sv
// Button conditioner: sync, debounce, multi-press reject, one-hot hold.
// Ports: clock, reset (sync, low), botoes_in[3:0], habilita -> botoes, valido, multiplo, db_estado.
module condicionador_botoes #(
  parameter int DEBOUNCE_CYCLES = 100
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botoes_in,
  input  logic       habilita,
  output logic [3:0] botoes,
  output logic       valido,
  output logic       multiplo,
  output logic [2:0] db_estado
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [2:0] {
    OCIOSO       = 3'd0,
    FILTRA_PRESS = 3'd1,
    PRESSIONADO  = 3'd2,
    FILTRA_SOLTA = 3'd3,
    ERRO         = 3'd4
  } estado_t;

  estado_t       estado_q, estado_d;
  logic [3:0]    sync_a_q, sync_a_d;
  logic [3:0]    sync_b_q, sync_b_d;
  logic [3:0]    amostra_q, amostra_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    botoes_q, botoes_d;
  logic          multiplo_q, multiplo_d;

  logic [3:0] s;
  logic       cnt_fim;
  logic       um_so;

  assign s       = sync_b_q;
  assign cnt_fim = (cnt_q == CNT_MAX);
  // exactly one bit set
  assign um_so   = (amostra_q != 4'd0) &&
                   ((amostra_q & (amostra_q - 4'd1)) == 4'd0);

  always_comb begin
    sync_a_d   = botoes_in;
    sync_b_d   = sync_a_q;
    estado_d   = estado_q;
    amostra_d  = amostra_q;
    cnt_d      = cnt_q;
    botoes_d   = botoes_q;
    multiplo_d = 1'b0;

    if (!habilita) begin
      // forced idle; synchronizer keeps tracking the lines
      estado_d = OCIOSO;
      cnt_d    = '0;
      botoes_d = 4'd0;
    end else begin
      unique case (estado_q)
        OCIOSO: begin
          botoes_d = 4'd0;
          if (s != 4'd0) begin
            amostra_d = s;
            cnt_d     = '0;
            estado_d  = FILTRA_PRESS;
          end
        end
        FILTRA_PRESS: begin
          if (s == 4'd0) begin
            estado_d = OCIOSO;
          end else if (s != amostra_q) begin
            amostra_d = s;
            cnt_d     = '0;
          end else if (cnt_fim) begin
            if (um_so) begin
              estado_d = PRESSIONADO;
              botoes_d = amostra_q;
            end else begin
              estado_d   = ERRO;
              multiplo_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        PRESSIONADO: begin
          botoes_d = amostra_q;
          if (s != amostra_q) begin
            cnt_d    = '0;
            estado_d = FILTRA_SOLTA;
          end
        end
        FILTRA_SOLTA: begin
          if (s == amostra_q) begin
            estado_d = PRESSIONADO;
          end else if (s != 4'd0) begin
            cnt_d = '0;
          end else if (cnt_fim) begin
            botoes_d = 4'd0;
            estado_d = OCIOSO;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ERRO: begin
          botoes_d = 4'd0;
          if (s != 4'd0) begin
            cnt_d = '0;
          end else if (cnt_fim) begin
            estado_d = OCIOSO;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          estado_d = OCIOSO;
          cnt_d    = '0;
          botoes_d = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_a_q   <= 4'd0;
      sync_b_q   <= 4'd0;
      estado_q   <= OCIOSO;
      amostra_q  <= 4'd0;
      cnt_q      <= '0;
      botoes_q   <= 4'd0;
      multiplo_q <= 1'b0;
    end else begin
      sync_a_q   <= sync_a_d;
      sync_b_q   <= sync_b_d;
      estado_q   <= estado_d;
      amostra_q  <= amostra_d;
      cnt_q      <= cnt_d;
      botoes_q   <= botoes_d;
      multiplo_q <= multiplo_d;
    end
  end

  assign botoes    = botoes_q;
  assign valido    = |botoes_q;
  assign multiplo  = multiplo_q;
  assign db_estado = estado_q;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Directed bench for condicionador_botoes (DEBOUNCE_CYCLES 4 and 1).
// Inputs change and outputs are sampled 1 time unit after rising edges.
module tb_condicionador_botoes;

  logic       clock;
  logic       reset;
  logic [3:0] botoes_in;
  logic       habilita;
  logic [3:0] botoes;
  logic       valido;
  logic       multiplo;
  logic [2:0] db_estado;
  logic [3:0] botoes1;
  logic       valido1;
  logic       multiplo1;
  logic [2:0] db_estado1;

  int errors = 0;
  int checks = 0;
  int subidas = 0;
  logic contar = 1'b0;
  logic valido_prev = 1'b0;

  condicionador_botoes #(.DEBOUNCE_CYCLES(4)) u_dut (
    .clock(clock), .reset(reset), .botoes_in(botoes_in),
    .habilita(habilita), .botoes(botoes), .valido(valido),
    .multiplo(multiplo), .db_estado(db_estado)
  );

  condicionador_botoes #(.DEBOUNCE_CYCLES(1)) u_dut1 (
    .clock(clock), .reset(reset), .botoes_in(botoes_in),
    .habilita(habilita), .botoes(botoes1), .valido(valido1),
    .multiplo(multiplo1), .db_estado(db_estado1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (contar && valido && !valido_prev) subidas++;
    valido_prev <= valido;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    habilita = 1'b1;
    botoes_in = 4'b0010;
    for (int i = 0; i < 2; i++) begin
      step(1);
      checks++;
      if (botoes !== 4'd0 || valido !== 1'b0 || multiplo !== 1'b0 || db_estado !== 3'd0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d botoes=%b valido=%b multiplo=%b estado=%0d exp 0/0/0/0",
                 i, botoes, valido, multiplo, db_estado);
      end
    end
    reset = 1'b1;
    step(1);
    checks++;
    if (db_estado !== 3'd0 || botoes !== 4'd0) begin
      errors++;
      $display("FAIL reset_release estado=%0d botoes=%b exp 0/0000", db_estado, botoes);
    end
    botoes_in = 4'd0;
    step(10);
  endtask

  task automatic test_clean_press;
    botoes_in = 4'b0100;
    step(3);
    checks++;
    if (botoes1 !== 4'd0) begin
      errors++;
      $display("FAIL d1_press_early botoes=%b exp 0000", botoes1);
    end
    step(1);
    checks++;
    if (botoes1 !== 4'b0100 || valido1 !== 1'b1) begin
      errors++;
      $display("FAIL d1_press botoes=%b valido=%b exp 0100/1", botoes1, valido1);
    end
    step(2);
    checks++;
    if (botoes !== 4'd0 || valido !== 1'b0) begin
      errors++;
      $display("FAIL press_early botoes=%b valido=%b exp 0000/0", botoes, valido);
    end
    step(1);
    checks++;
    if (botoes !== 4'b0100 || valido !== 1'b1 || db_estado !== 3'd2) begin
      errors++;
      $display("FAIL press_on botoes=%b valido=%b estado=%0d exp 0100/1/2",
               botoes, valido, db_estado);
    end
    step(13);
    botoes_in = 4'd0;
    step(6);
    checks++;
    if (botoes !== 4'b0100) begin
      errors++;
      $display("FAIL release_early botoes=%b exp 0100", botoes);
    end
    step(1);
    checks++;
    if (botoes !== 4'd0 || valido !== 1'b0 || db_estado !== 3'd0) begin
      errors++;
      $display("FAIL release_off botoes=%b valido=%b estado=%0d exp 0000/0/0",
               botoes, valido, db_estado);
    end
    step(5);
  endtask

  task automatic test_bounce;
    int bad;
    bad = 0;
    contar = 1'b1;
    for (int seg = 0; seg < 6; seg++) begin
      botoes_in = (seg % 2 == 0) ? 4'b0001 : 4'b0000;
      for (int c = 0; c < 2; c++) begin
        step(1);
        if (botoes !== 4'd0) bad++;
      end
    end
    botoes_in = 4'b0001;
    for (int c = 0; c < 6; c++) begin
      step(1);
      if (botoes !== 4'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bounce_quiet nonzero_cycles=%0d exp 0", bad);
    end
    step(1);
    checks++;
    if (botoes !== 4'b0001) begin
      errors++;
      $display("FAIL bounce_accept botoes=%b exp 0001", botoes);
    end
    step(4);
    contar = 1'b0;
    checks++;
    if (subidas != 1) begin
      errors++;
      $display("FAIL bounce_rises valido_rises=%0d exp 1", subidas);
    end
    botoes_in = 4'd0;
    step(10);
  endtask

  task automatic test_release_bounce;
    botoes_in = 4'b0010;
    step(7);
    checks++;
    if (botoes !== 4'b0010) begin
      errors++;
      $display("FAIL rb_press botoes=%b exp 0010", botoes);
    end
    botoes_in = 4'd0;
    step(3);
    botoes_in = 4'b0010;
    step(2);
    botoes_in = 4'd0;
    step(1);
    checks++;
    if (botoes !== 4'b0010 || db_estado !== 3'd2) begin
      errors++;
      $display("FAIL rb_back botoes=%b estado=%0d exp 0010/2", botoes, db_estado);
    end
    step(5);
    checks++;
    if (botoes !== 4'b0010) begin
      errors++;
      $display("FAIL rb_restart botoes=%b exp 0010", botoes);
    end
    step(1);
    checks++;
    if (botoes !== 4'd0) begin
      errors++;
      $display("FAIL rb_off botoes=%b exp 0000", botoes);
    end
    step(5);
  endtask

  task automatic test_multiple;
    botoes_in = 4'b1001;
    step(6);
    checks++;
    if (multiplo !== 1'b0 || db_estado !== 3'd1) begin
      errors++;
      $display("FAIL multi_pre multiplo=%b estado=%0d exp 0/1", multiplo, db_estado);
    end
    step(1);
    checks++;
    if (multiplo !== 1'b1 || botoes !== 4'd0 || db_estado !== 3'd4) begin
      errors++;
      $display("FAIL multi_pulse multiplo=%b botoes=%b estado=%0d exp 1/0000/4",
               multiplo, botoes, db_estado);
    end
    step(1);
    checks++;
    if (multiplo !== 1'b0 || db_estado !== 3'd4 || valido !== 1'b0) begin
      errors++;
      $display("FAIL multi_after multiplo=%b estado=%0d valido=%b exp 0/4/0",
               multiplo, db_estado, valido);
    end
    step(3);
    botoes_in = 4'd0;
    step(5);
    checks++;
    if (db_estado !== 3'd4) begin
      errors++;
      $display("FAIL multi_hold estado=%0d exp 4", db_estado);
    end
    step(2);
    checks++;
    if (db_estado !== 3'd0 || multiplo !== 1'b0) begin
      errors++;
      $display("FAIL multi_exit estado=%0d multiplo=%b exp 0/0", db_estado, multiplo);
    end
    step(5);
  endtask

  task automatic test_disable_reset;
    botoes_in = 4'b1000;
    step(7);
    checks++;
    if (botoes !== 4'b1000 || db_estado !== 3'd2) begin
      errors++;
      $display("FAIL dis_press botoes=%b estado=%0d exp 1000/2", botoes, db_estado);
    end
    habilita = 1'b0;
    step(1);
    checks++;
    if (botoes !== 4'd0 || db_estado !== 3'd0 || valido !== 1'b0) begin
      errors++;
      $display("FAIL dis_clear botoes=%b estado=%0d valido=%b exp 0000/0/0",
               botoes, db_estado, valido);
    end
    habilita = 1'b1;
    step(1);
    checks++;
    if (db_estado !== 3'd1) begin
      errors++;
      $display("FAIL dis_refilter estado=%0d exp 1", db_estado);
    end
    step(3);
    checks++;
    if (botoes !== 4'd0) begin
      errors++;
      $display("FAIL dis_early botoes=%b exp 0000", botoes);
    end
    step(1);
    checks++;
    if (botoes !== 4'b1000) begin
      errors++;
      $display("FAIL dis_repress botoes=%b exp 1000", botoes);
    end
    reset = 1'b0;
    step(1);
    checks++;
    if (botoes !== 4'd0 || db_estado !== 3'd0 || multiplo !== 1'b0) begin
      errors++;
      $display("FAIL rst_clear botoes=%b estado=%0d multiplo=%b exp 0000/0/0",
               botoes, db_estado, multiplo);
    end
    reset = 1'b1;
    step(6);
    checks++;
    if (botoes !== 4'd0) begin
      errors++;
      $display("FAIL rst_early botoes=%b exp 0000", botoes);
    end
    step(1);
    checks++;
    if (botoes !== 4'b1000) begin
      errors++;
      $display("FAIL rst_repress botoes=%b exp 1000", botoes);
    end
    botoes_in = 4'd0;
    step(10);
  endtask

  initial begin
    reset = 1'b0;
    habilita = 1'b1;
    botoes_in = 4'd0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_bounce();
    test_multiple();
    test_disable_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/condicionador_botoes.md
# condicionador_botoes

Input conditioning stage between the raw push-buttons and the game datapath's `botoes` bus. It does four things:
- synchronizes the four asynchronous button lines;
- debounces press and release with a shared counter;
- rejects simultaneous multi-button presses;
- presents a clean, held one-hot code downstream.

Because the downstream edge detector ORs the bus, `botoes` rises exactly once per accepted press. It never glitches during bounce.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 100, number of consecutive stable clock cycles required to accept a press or release; must be ≥ 1 (100 = 20 ms at 5 kHz)

Ports:
- `clock`  in  1  system clock, all logic on rising edge
- `reset`  in  1  one clock; reset is synchronous and active-low
- `botoes_in`  in  4  raw, asynchronous, bouncing button lines, active-high
- `habilita`  in  1  1 = conditioning active; 0 = forced idle
- `botoes`  out  4  debounced one-hot button code, held for the whole press; 0 otherwise
- `valido`  out  1  1 while `botoes` is non-zero
- `multiplo`  out  1  one-cycle pulse when a debounced press has more than one bit set
- `db_estado`  out  3  current FSM state encoding, for debug

## Operation
- Each bit passes through a 2-flop synchronizer. The synchronized value is `s` (4 bits).
- There is a sample register `amostra` (4 bits) and a counter `cnt` of width `$clog2(DEBOUNCE_CYCLES+1)`.
- FSM states and encodings:
  - `OCIOSO`: 0
  - `FILTRA_PRESS`: 1
  - `PRESSIONADO`: 2
  - `FILTRA_SOLTA`: 3
  - `ERRO`: 4
- `OCIOSO`:
  - outputs are 0;
  - if `s != 0`: `amostra <= s`, `cnt <= 0`, go to `FILTRA_PRESS`.
- `FILTRA_PRESS`:
  - if `s == 0`: go to `OCIOSO`;
  - else if `s != amostra`: `amostra <= s`, `cnt <= 0`, stay;
  - else if `cnt == DEBOUNCE_CYCLES-1`:
    - if `amostra` is one-hot: go to `PRESSIONADO`, `botoes <= amostra`;
    - otherwise: go to `ERRO`, `multiplo <= 1` for that one cycle;
  - else `cnt <= cnt+1`.
- `PRESSIONADO`:
  - `botoes` holds `amostra`;
  - if `s != amostra`: `cnt <= 0`, go to `FILTRA_SOLTA`.
- `FILTRA_SOLTA`:
  - `botoes` still holds `amostra`;
  - if `s == amostra`: return to `PRESSIONADO`;
  - else if `s != 0`: `cnt <= 0`, stay;
  - else if `cnt == DEBOUNCE_CYCLES-1`: `botoes <= 0`, go to `OCIOSO`;
  - else `cnt <= cnt+1`.
- `ERRO`:
  - `botoes = 0`;
  - if `s != 0`: `cnt <= 0`;
  - else if `cnt == DEBOUNCE_CYCLES-1`: go to `OCIOSO`;
  - else `cnt <= cnt+1`.
- `valido` is the combinational OR of `botoes`.
- `habilita == 0` has priority over every transition:
  - state goes to `OCIOSO`, `cnt <= 0`, `botoes <= 0`, `multiplo <= 0`;
  - the synchronizer keeps running.
  - A button held while `habilita` rises is debounced from that point as a new press.
- `reset == 0` on a clock edge overrides everything, including `habilita`:
  - synchronizer flops, `amostra`, `cnt`, `botoes` and `multiplo` go to 0;
  - state goes to `OCIOSO`.
  - The same applies mid-press: `botoes` drops to 0 on that edge.

## Timing
- Reset values:
  - `botoes` = 0, `valido` = 0, `multiplo` = 0, `db_estado` = 0;
  - all internal registers = 0.
- `botoes` and `multiplo` are registered; `valido` is derived from `botoes`, so it is registered-equivalent.
- Press latency, for raw input stable from rising edge k:
  - `s` reflects it after edge k+2;
  - `FILTRA_PRESS` is entered at edge k+3;
  - `botoes` is valid after edge k+3+`DEBOUNCE_CYCLES`.
- Release latency: same formula, measured from a stable-zero raw input. `botoes` returns to 0 after edge k+3+`DEBOUNCE_CYCLES`.
- Any bounce inside a filter window restarts the window. There is no partial credit.
- `cnt` never exceeds `DEBOUNCE_CYCLES-1` and does not wrap.
- `DEBOUNCE_CYCLES == 1`: a value stable for a single synchronized cycle is accepted.
- `multiplo` is high for exactly one cycle per rejected press. It is never high while `botoes != 0`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4 and `reset` = 1, `habilita` = 1 unless stated.
- Reset: hold `reset` = 0 for 2 cycles with `botoes_in` = 4'b0010 → `botoes` = 0, `valido` = 0, `multiplo` = 0, `db_estado` = 0 throughout, and `db_estado` = 0 on the first edge after release.
- Clean press: `botoes_in` = 4'b0100 from edge 10 → `botoes` = 4'b0100 and `valido` = 1 from edge 17. Release at edge 30 → `botoes` = 0 from edge 37.
- Bounce: toggle `botoes_in` between 4'b0001 and 0 every 2 cycles for 10 cycles, then hold 4'b0001 from edge k → `botoes` stays 0 during bouncing and becomes 4'b0001 at edge k+7. Exactly one rising transition on `valido`.
- Multiple press: `botoes_in` = 4'b1001 stable from edge 5 → `multiplo` = 1 only at edge 12, `botoes` = 0, `db_estado` = 4. Release → `db_estado` = 0 at edge k+7 after the release edge k.
- Disable/reset mid-press: during `PRESSIONADO` with `botoes` = 4'b1000, drop `habilita` → `botoes` = 0 and `db_estado` = 0 on the next edge. Re-raise `habilita` with the button still held → `botoes` = 4'b1000 again 4 cycles after re-entering `FILTRA_PRESS`. Repeat with `reset` = 0 for 1 cycle → same clearing.
